// File: rtl/note_lanes_if.sv
// Command, pixel and score signals between the pattern source / vga path and note_lanes.
// The master side drives requests and pixel coordinates; the slave side is the engine.
interface note_lanes_if #(
   parameter int LANES = 4
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic             spawn_valid;
   logic [LW-1:0]    spawn_lane;
   logic             spawn_ready;
   logic             frame_tick;
   logic [LANES-1:0] hit;
   logic [9:0]       next_x;
   logic [9:0]       next_y;
   logic [7:0]       R_in, G_in, B_in;
   logic [7:0]       R_out, G_out, B_out;
   logic [15:0]      score_hit;
   logic [15:0]      score_miss;

   modport master (
      output spawn_valid, spawn_lane, frame_tick, hit, next_x, next_y, R_in, G_in, B_in,
      input  spawn_ready, R_out, G_out, B_out, score_hit, score_miss
   );

   modport slave (
      input  spawn_valid, spawn_lane, frame_tick, hit, next_x, next_y, R_in, G_in, B_in,
      output spawn_ready, R_out, G_out, B_out, score_hit, score_miss
   );
endinterface

// File: rtl/note_lanes.sv
// Multi-lane falling-note engine: slot bookkeeping, hit/miss scoring and a
// registered compositor that blends note sprites and the hit line over the background.
module note_lanes #(
   parameter int LANES    = 4,
   parameter int SLOTS    = 8,
   parameter int X0       = 192,
   parameter int LANE_W   = 64,
   parameter int NOTE_H   = 16,
   parameter int SPEED    = 2,
   parameter int V_ACTIVE = 480,
   parameter int HIT_Y    = 440,
   parameter int HIT_WIN  = 16,
   parameter int ALPHA    = 1
) (
   input logic       CLOCK_25,
   input logic       reset_n,
   note_lanes_if.slave bus
);
   localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int SW     = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int MCW    = $clog2(LANES * SLOTS + 1);
   localparam int HCW    = $clog2(LANES + 1);
   localparam int SPAN   = LANES * LANE_W;
   // Window on the note's top edge equivalent to |y + NOTE_H/2 - HIT_Y| <= HIT_WIN
   localparam int WIN_LO = HIT_Y - HIT_WIN - NOTE_H / 2;
   localparam int WIN_HI = HIT_Y + HIT_WIN - NOTE_H / 2;

   logic [SLOTS-1:0] valid     [LANES];
   logic [9:0]       pos       [LANES][SLOTS];
   logic [SLOTS-1:0] valid_nxt [LANES];
   logic [9:0]       pos_nxt   [LANES][SLOTS];
   logic [SLOTS-1:0] hit_sel   [LANES];
   logic [LANES-1:0] hit_take;
   logic             spawn_ok;
   logic [SW-1:0]    free_i;
   logic [MCW-1:0]   miss_cnt;
   logic [HCW-1:0]   hit_cnt;
   logic [16:0]      hit_sum, miss_sum;
   logic [15:0]      score_hit_q, score_miss_q;
   logic [23:0]      pix, rgb_q;

   always_comb begin
      logic       found;
      logic [9:0] best_y;
      logic [SW-1:0] best_i;
      for (int unsigned l = 0; l < LANES; l++) begin
         hit_sel[l] = '0;
         found      = 1'b0;
         best_y     = '0;
         best_i     = '0;
         for (int unsigned s = 0; s < SLOTS; s++) begin
            if (valid[l][s] && int'(pos[l][s]) >= WIN_LO && int'(pos[l][s]) <= WIN_HI &&
                (!found || pos[l][s] > best_y)) begin
               found  = 1'b1;
               best_y = pos[l][s];
               best_i = SW'(s);
            end
         end
         hit_take[l]        = found && bus.hit[l];
         hit_sel[l][best_i] = hit_take[l];
      end
   end

   // Readiness uses pre-cycle occupancy, so a same-cycle expiry never frees a slot early
   always_comb begin
      logic found;
      spawn_ok = 1'b0;
      free_i   = '0;
      found    = 1'b0;
      for (int unsigned l = 0; l < LANES; l++) begin
         if (LW'(l) == bus.spawn_lane) begin
            for (int unsigned s = 0; s < SLOTS; s++) begin
               if (!valid[l][s] && !found) begin
                  found  = 1'b1;
                  free_i = SW'(s);
               end
            end
         end
      end
      spawn_ok = found && bus.spawn_valid;
   end

   assign bus.spawn_ready = (free_i != '0) || (spawn_ok) || (|free_scan());

   function automatic logic free_scan();
      logic r;
      r = 1'b0;
      for (int unsigned l = 0; l < LANES; l++)
         if (LW'(l) == bus.spawn_lane && !(&valid[l])) r = 1'b1;
      return r;
   endfunction

   always_comb begin
      logic [10:0] adv;
      miss_cnt = '0;
      hit_cnt  = '0;
      for (int unsigned l = 0; l < LANES; l++) begin
         valid_nxt[l] = valid[l];
         if (hit_take[l]) hit_cnt = hit_cnt + HCW'(1);
         for (int unsigned s = 0; s < SLOTS; s++) begin
            pos_nxt[l][s] = pos[l][s];
            adv           = {1'b0, pos[l][s]} + 11'(SPEED);
            if (hit_sel[l][s]) begin
               valid_nxt[l][s] = 1'b0;
            end else if (valid[l][s] && bus.frame_tick) begin
               if (adv >= 11'(V_ACTIVE)) begin
                  valid_nxt[l][s] = 1'b0;
                  miss_cnt        = miss_cnt + MCW'(1);
               end else begin
                  pos_nxt[l][s] = adv[9:0];
               end
            end
            if (spawn_ok && LW'(l) == bus.spawn_lane && SW'(s) == free_i) begin
               valid_nxt[l][s] = 1'b1;
               pos_nxt[l][s]   = '0;
            end
         end
      end
      hit_sum  = {1'b0, score_hit_q} + 17'(hit_cnt);
      miss_sum = {1'b0, score_miss_q} + 17'(miss_cnt);
   end

   always_comb begin
      logic        in_span, note_px;
      int          lane_i;
      logic [23:0] note_rgb;
      in_span  = int'(bus.next_x) >= X0 && int'(bus.next_x) < X0 + SPAN;
      lane_i   = in_span ? (int'(bus.next_x) - X0) / LANE_W : 0;
      note_px  = 1'b0;
      for (int unsigned l = 0; l < LANES; l++)
         for (int unsigned s = 0; s < SLOTS; s++)
            if (in_span && lane_i == int'(l) && valid[l][s] && bus.next_y >= pos[l][s] &&
                {1'b0, bus.next_y} < {1'b0, pos[l][s]} + 11'(NOTE_H))
               note_px = 1'b1;
      case (lane_i % 4)
         0:       note_rgb = 24'hFF0000;
         1:       note_rgb = 24'h00FF00;
         2:       note_rgb = 24'h0000FF;
         default: note_rgb = 24'hFFFF00;
      endcase
      pix = {bus.R_in, bus.G_in, bus.B_in};
      if (in_span && int'(bus.next_y) == HIT_Y)
         pix = '1;
      else if (in_span && note_px)
         pix = (ALPHA != 0) ? {(bus.R_in >> 1) + (note_rgb[23:16] >> 1),
                               (bus.G_in >> 1) + (note_rgb[15:8] >> 1),
                               (bus.B_in >> 1) + (note_rgb[7:0] >> 1)} : note_rgb;
   end

   always_ff @(posedge CLOCK_25 or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned l = 0; l < LANES; l++) begin
            valid[l] <= '0;
            for (int unsigned s = 0; s < SLOTS; s++) pos[l][s] <= '0;
         end
         score_hit_q  <= '0;
         score_miss_q <= '0;
         rgb_q        <= '0;
      end else begin
         for (int unsigned l = 0; l < LANES; l++) begin
            valid[l] <= valid_nxt[l];
            for (int unsigned s = 0; s < SLOTS; s++) pos[l][s] <= pos_nxt[l][s];
         end
         score_hit_q  <= hit_sum[16] ? '1 : hit_sum[15:0];
         score_miss_q <= miss_sum[16] ? '1 : miss_sum[15:0];
         rgb_q        <= pix;
      end
   end

   assign bus.score_hit  = score_hit_q;
   assign bus.score_miss = score_miss_q;
   assign bus.R_out      = rgb_q[23:16];
   assign bus.G_out      = rgb_q[15:8];
   assign bus.B_out      = rgb_q[7:0];
endmodule
